keypad_scanner: RTL and testbench

//  Scans a 4x3 Pmod keypad. Drives one row at a time and reads three column inputs through 2-flop synchronisers.

---
 rtl/keypad_scanner.sv | 110 +++++++++++
 tb/tb_keypad_scanner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 keypad row scanner with debounced key latch and MCU interrupt pulse
module keypad_scanner #(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int INTR_CYCLES    = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       C,
  input  logic       A,
  input  logic       E,
  output logic       B,
  output logic       G,
  output logic       F,
  output logic       D,
  output logic [3:0] DATA,
  output logic       INTERRUPT,
  output logic [2:0] STATE_PMOD
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PW = $clog2(INTR_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_SCANS - 1);
  localparam logic [PW-1:0] IRQ_LAST = PW'(INTR_CYCLES - 1);
  typedef enum logic [2:0] {SCAN = 3'd0, PRESS_DB = 3'd1, PULSE = 3'd2, HELD = 3'd3, REL_DB = 3'd4} state_t;
  state_t state, state_nx;
  logic [2:0] col_s1, col_s2;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] db_cnt, db_cnt_nx;
  logic [PW-1:0] pulse_cnt;
  logic [1:0] row, row_nx, col_r, col_r_nx, col_now;
  logic [3:0] data_nx, code;
  logic tick, hit;
  assign tick = div_cnt == DIV_LAST;
  assign hit = |col_s2;
  assign col_now = col_s2[0] ? 2'd0 : col_s2[1] ? 2'd1 : 2'd2;
  // Row 3 holds the non-numeric keys; rows 0..2 map to 1..9 as row*3+col+1
  assign code = (row == 2'd3) ? ((col_r == 2'd0) ? 4'hA : (col_r == 2'd1) ? 4'h0 : 4'hB)
                              : 4'd1 + {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col_r};
  assign {D, F, G, B} = 4'd1 << row;
  assign INTERRUPT = state == PULSE;
  assign STATE_PMOD = state;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      {col_s2, col_s1} <= '0;
      div_cnt <= '0;
      pulse_cnt <= '0;
      db_cnt <= '0;
      state <= SCAN;
      row <= '0;
      col_r <= '0;
      DATA <= '0;
    end else begin
      {col_s2, col_s1} <= {col_s1, E, A, C};
      div_cnt <= (tick || (state_nx == SCAN && state != SCAN)) ? '0 : div_cnt + DW'(1);
      pulse_cnt <= (state == PULSE) ? pulse_cnt + PW'(1) : '0;
      db_cnt <= db_cnt_nx;
      state <= state_nx;
      row <= row_nx;
      col_r <= col_r_nx;
      DATA <= data_nx;
    end
  end
  always_comb begin
    state_nx = state;
    row_nx = row;
    col_r_nx = col_r;
    db_cnt_nx = db_cnt;
    data_nx = DATA;
    case (state)
      SCAN:
        if (tick && hit) begin
          state_nx = PRESS_DB;
          col_r_nx = col_now;
          db_cnt_nx = BW'(1);
        end else if (tick)
          row_nx = row + 2'd1;
      PRESS_DB:
        if (tick && hit && col_now == col_r) begin
          db_cnt_nx = db_cnt + BW'(1);
          if (db_cnt == DB_LAST) begin
            state_nx = PULSE;
            data_nx = code;
          end
        end else if (tick) begin
          state_nx = SCAN;
          row_nx = row + 2'd1;
        end
      PULSE:
        if (pulse_cnt == IRQ_LAST) state_nx = HELD;
      HELD:
        if (tick && !hit) begin
          state_nx = REL_DB;
          db_cnt_nx = BW'(1);
        end
      REL_DB:
        if (tick && hit)
          state_nx = HELD;
        else if (tick) begin
          db_cnt_nx = db_cnt + BW'(1);
          if (db_cnt == DB_LAST) begin
            state_nx = SCAN;
            row_nx = row + 2'd1;
          end
        end
      default: state_nx = SCAN;
    endcase
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, interrupt pulse and async reset
module tb_keypad_scanner;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [11:0] keys = '0;
  logic C, A, E, B, G, F, D, INTERRUPT;
  logic [3:0] DATA;
  logic [2:0] STATE_PMOD;
  int checks = 0;
  int errors = 0;
  int rises = 0;
  logic irq_q = 1'b0;
  int n, r0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .INTR_CYCLES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .C(C), .A(A), .E(E), .B(B), .G(G), .F(F), .D(D),
    .DATA(DATA), .INTERRUPT(INTERRUPT), .STATE_PMOD(STATE_PMOD));

  always #5 CLK = ~CLK;

  // keypad matrix: key index row*3+col closes its column onto the driven row
  assign C = (B & keys[0]) | (G & keys[3]) | (F & keys[6]) | (D & keys[9]);
  assign A = (B & keys[1]) | (G & keys[4]) | (F & keys[7]) | (D & keys[10]);
  assign E = (B & keys[2]) | (G & keys[5]) | (F & keys[8]) | (D & keys[11]);

  always @(posedge CLK) begin
    if (INTERRUPT && !irq_q) rises++;
    irq_q = INTERRUPT;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, output int cnt);
    cnt = 0;
    while (STATE_PMOD !== s && cnt < lim) begin
      @(negedge CLK);
      cnt++;
    end
  endtask

  task automatic wait_irq(input int lim, output int cnt);
    cnt = 0;
    while (INTERRUPT !== 1'b1 && cnt < lim) begin
      @(negedge CLK);
      cnt++;
    end
  endtask

  initial begin
    #1;
    chk("rst_rows", {D, F, G, B}, 4'b0001);
    chk("rst_data", DATA, 4'h0);
    chk("rst_irq", INTERRUPT, 1'b0);
    chk("rst_state", STATE_PMOD, 3'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("rot_start", {D, F, G, B}, 4'b0001 << (i % 4));
      repeat (3) @(negedge CLK);
      chk("rot_end", {D, F, G, B}, 4'b0001 << (i % 4));
      @(negedge CLK);
    end
    chk("idle_irq", rises, 0);
    chk("idle_data", DATA, 4'h0);

    keys[4] = 1'b1;
    wait_state(3'd1, 100, n);
    chk("k5_press_db", STATE_PMOD, 3'd1);
    chk("k5_row", {D, F, G, B}, 4'b0010);
    wait_irq(50, n);
    chk("k5_latency", n, 8);
    chk("k5_data", DATA, 4'h5);
    chk("k5_pulse_state", STATE_PMOD, 3'd2);
    n = 0;
    while (INTERRUPT === 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("k5_width", n, 4);
    chk("k5_held", STATE_PMOD, 3'd3);
    repeat (12) @(negedge CLK);
    chk("k5_no_repeat", rises, 1);
    chk("k5_row_frozen", {D, F, G, B}, 4'b0010);
    keys = '0;
    wait_state(3'd4, 50, n);
    chk("k5_rel_db", STATE_PMOD, 3'd4);
    wait_state(3'd0, 50, n);
    chk("k5_scan", STATE_PMOD, 3'd0);
    chk("k5_row_adv", {D, F, G, B}, 4'b0100);
    chk("k5_data_hold", DATA, 4'h5);

    keys[11] = 1'b1;
    wait_state(3'd1, 100, n);
    chk("hash_press_db", STATE_PMOD, 3'd1);
    chk("hash_row", {D, F, G, B}, 4'b1000);
    repeat (4) @(negedge CLK);
    chk("hash_still_db", STATE_PMOD, 3'd1);
    keys = '0;
    wait_state(3'd0, 20, n);
    chk("hash_abort", STATE_PMOD, 3'd0);
    chk("hash_row_adv", {D, F, G, B}, 4'b0001);
    chk("hash_data", DATA, 4'h5);
    chk("hash_no_irq", rises, 1);

    keys[9] = 1'b1;
    keys[10] = 1'b1;
    wait_irq(200, n);
    chk("star0_irq", INTERRUPT, 1'b1);
    chk("star0_data", DATA, 4'hA);
    repeat (20) @(negedge CLK);
    chk("star0_one_pulse", rises, 2);
    keys = '0;
    wait_state(3'd0, 100, n);
    chk("star0_scan", STATE_PMOD, 3'd0);

    keys[6] = 1'b1;
    wait_irq(200, n);
    chk("k7_data", DATA, 4'h7);
    repeat (80) @(negedge CLK);
    chk("k7_held", STATE_PMOD, 3'd3);
    keys = '0;
    wait_state(3'd4, 20, n);
    chk("k7_rel_db1", STATE_PMOD, 3'd4);
    keys[6] = 1'b1;
    repeat (3) @(negedge CLK);
    keys = '0;
    wait_state(3'd3, 20, n);
    chk("k7_bounce_held", STATE_PMOD, 3'd3);
    wait_state(3'd4, 20, n);
    chk("k7_rel_db2", STATE_PMOD, 3'd4);
    wait_state(3'd0, 40, n);
    chk("k7_release_time", n, 8);
    chk("k7_one_pulse", rises, 3);
    chk("k7_data_hold", DATA, 4'h7);

    keys[0] = 1'b1;
    wait_irq(200, n);
    chk("k1_data", DATA, 4'h1);
    @(negedge CLK);
    chk("k1_mid_pulse", INTERRUPT, 1'b1);
    RST_N = 1'b0;
    #1;
    chk("arst_irq", INTERRUPT, 1'b0);
    chk("arst_data", DATA, 4'h0);
    chk("arst_state", STATE_PMOD, 3'd0);
    chk("arst_rows", {D, F, G, B}, 4'b0001);
    keys = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    chk("post_rst_irq", INTERRUPT, 1'b0);
    chk("post_rst_state", STATE_PMOD, 3'd0);
    r0 = rises;
    chk("post_rst_rises", r0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
